enet_rx_ddr_packer: RTL
=======================

# enet_rx_ddr_packer

Receive-side DMA packer between the Ethernet MAC receive byte stream and the 256-bit DDR controller write port. It gathers received bytes into 32-byte words and issues one DDR write per word at incrementing addresses from the programmed destination. It stops after the programmed byte count, reports completion and a cycle-count performance figure, and drives the `o_ddr_wr_*` / `o_enet_rx_*` signals presented by the Ethernet top level.

## Interface
Parameters:
- `DDR_DW`, default 256: DDR data width in bits. Fixed at 256; the byte-enable width is `DDR_DW/8` = 32.
- `ADDR_STEP`, default 32: address increment per DDR write, in bytes.

Ports:
- `i_clk` in 1: single clock. Everything is synchronous to it.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_enet_enable` in 1: run level. A 0→1 transition starts a transfer.
- `i_enet_ddr_dest_addr` in 32: DDR byte address of the first word. Bits [4:0] are ignored and treated as 0.
- `i_enet_rcv_data_size` in 32: number of bytes to receive.
- `i_rx_data` in 8: received byte.
- `i_rx_valid` in 1: `i_rx_data` is valid.
- `i_rx_last` in 1: last byte of a frame.
- `o_rx_ready` out 1: block accepts a byte this cycle.
- `o_ddr_wr_req` out 1: DDR write request.
- `o_ddr_wr_addr` out 32: write address.
- `o_ddr_wr_data` out 256: write data.
- `o_ddr_wr_be` out 32: byte enables, one per byte.
- `i_ddr_wr_ack` in 1: controller accepted the request.
- `o_enet_rx_done` out 1: transfer complete.
- `o_enet_rx_cnt` out 32: performance counter, in cycles.

## Operation
- States are IDLE, FILL, WRITE and DONE.
- **IDLE.**
  - On a rising edge of `i_enet_enable`, latch the address with bits [4:0] cleared and latch the size.
  - Clear the byte count, lane index, `o_wr_be` and `o_enet_rx_cnt`.
  - Go to FILL, or to DONE directly if the size is 0.
- **FILL.**
  - `o_rx_ready`=1 only in this state.
  - An accepted byte (`i_rx_valid` & `o_rx_ready`) is written to `o_ddr_wr_data[8*k+7:8*k]` and sets `o_ddr_wr_be[k]`, where k is the lane index 0..31. The lane index and byte count then increment.
  - FILL → WRITE when the accepted byte fills lane 31, or makes the byte count equal the size, or has `i_rx_last`=1.
- **WRITE.**
  - `o_ddr_wr_req`=1 and is held, with addr/data/be stable, until `i_ddr_wr_ack`.
  - In the ack cycle: add `ADDR_STEP` to the address, clear the lane index and `be`, and clear the data to 0.
  - Then go to DONE if the byte count equals the size, otherwise to FILL.
- **Partial words.** Unused lanes have `be`=0 and data 0. A frame ending on `i_rx_last` leaves the next frame starting at the next 32-byte-aligned address.
- **DONE.** `o_enet_rx_done`=1 and `o_rx_ready`=0. Bytes beyond the size are never consumed.
- **Enable low.**
  - Dropping `i_enet_enable` in FILL or DONE returns to IDLE on the next cycle and clears done. Bytes held in a partial word are discarded.
  - Dropping it in WRITE completes the pending handshake first, then returns to IDLE.
- **Performance counter.** `o_enet_rx_cnt` increments every cycle in FILL and WRITE, saturates at 0xFFFFFFFF, and is frozen in DONE and IDLE.
- **Arithmetic.**
  - The byte count is 32-bit and is compared for equality with the latched size.
  - The address wraps modulo 2^32 with no error.

## Timing
- **Reset values.**
  - All outputs 0.
  - State IDLE.
  - Internal address, count and size registers 0.
- **Ready.** `o_rx_ready` is decoded from state, with no combinational path from `i_rx_valid`.
- **Request latency.** The request is registered: `o_ddr_wr_req` rises in the cycle after the byte that completes a word is accepted.
- **Ack timing.** `i_ddr_wr_ack` may be asserted in the first request cycle. `o_ddr_wr_req` is 0 in the cycle after the ack.
- **Ack outside WRITE.** `i_ddr_wr_ack` is ignored when `o_ddr_wr_req`=0.
- **Throughput.** Minimum 33 cycles per full word with no back-to-back buffering: 32 fill cycles plus 1 write cycle.
- **Done.** `o_enet_rx_done` rises in the cycle after the ack of the final word.
- **Asynchronous reset mid-transfer.** Immediate return to IDLE with all outputs 0. The pending request is dropped; the controller must tolerate this.
- **Start re-arm.** Start requires a fresh 0→1 edge of `i_enet_enable`. Holding enable high after DONE does not restart.

## Test plan
- **Full words.**
  - Stimulus: dest=0x1000_0010, size=64, bytes 0x00..0x3F continuously valid.
  - Response: two writes, to 0x1000_0000 and 0x1000_0020, each with be=0xFFFFFFFF.
  - Response: data lane k = byte index, i.e. lane k = k for the first word and k+32 for the second.
  - Response: done=1, rx_cnt=66.
- **Partial final word.**
  - Stimulus: size=40.
  - Response: second write has be=0x000000FF and data lanes 8..31 = 0.
  - Response: `o_rx_ready`=0 after done, and the 41st byte is not consumed.
- **Frame boundary.**
  - Stimulus: a 5-byte frame with `i_rx_last` on byte 5, then 3 more bytes; size=8.
  - Response: writes at base with be=0x1F, then base+0x20 with be=0x07.
- **Ack stall.**
  - Stimulus: hold `i_ddr_wr_ack` low for 10 cycles.
  - Response: req/addr/data/be stable for all 10 cycles and `o_rx_ready`=0 throughout.
  - Response: a single write is accepted and rx_cnt includes the stall cycles.
- **Zero size and re-arm.**
  - Stimulus: size=0 with an enable rising edge.
  - Response: done on the second cycle, with no request.
  - Stimulus: enable low, then high again with size=32.
  - Response: one write and rx_cnt cleared.
- **Abort.**
  - Stimulus: deassert enable after 10 bytes, in FILL.
  - Response: no write and IDLE next cycle.
  - Stimulus: pulse `i_rst_n` low during WRITE.
  - Response: req=0 immediately and all outputs 0.

Source files
------------

// File: rtl/enet_rx_ddr_packer.sv
// Ethernet receive-to-DDR packer: gathers received bytes into DDR-width words
// and writes them to consecutive aligned addresses until the byte budget is met.
module enet_rx_ddr_packer #(
    parameter int DDR_DW    = 256,
    parameter int ADDR_STEP = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enet_enable,
    input  logic [31:0]           i_enet_ddr_dest_addr,
    input  logic [31:0]           i_enet_rcv_data_size,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_rx_last,
    output logic                  o_rx_ready,
    output logic                  o_ddr_wr_req,
    output logic [31:0]           o_ddr_wr_addr,
    output logic [DDR_DW-1:0]     o_ddr_wr_data,
    output logic [DDR_DW/8-1:0]   o_ddr_wr_be,
    input  logic                  i_ddr_wr_ack,
    output logic                  o_enet_rx_done,
    output logic [31:0]           o_enet_rx_cnt
);
    localparam int LANES = DDR_DW / 8;
    localparam int LW    = $clog2(LANES);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [LW-1:0] LANE_ONE  = LW'(1);
    localparam logic [31:0]   STEP      = 32'(ADDR_STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              en_prev_q, en_prev_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       size_q, size_d;
    logic [31:0]       count_q, count_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic [DDR_DW-1:0] data_q, data_d;
    logic [LANES-1:0]  be_q, be_d;
    logic              req_q, req_d;

    logic              start_s;
    logic              word_end_s;
    logic [31:0]       count_inc_s;

    assign start_s     = i_enet_enable & ~en_prev_q;
    assign count_inc_s = count_q + 32'd1;
    // A word closes on the last lane, the final byte of the budget, or a frame end.
    assign word_end_s  = (lane_q == LAST_LANE) || (count_inc_s == size_q) || i_rx_last;

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        en_prev_d = i_enet_enable;
        addr_d    = addr_q;
        size_d    = size_q;
        count_d   = count_q;
        lane_d    = lane_q;
        data_d    = data_q;
        be_d      = be_q;
        req_d     = req_q;
        if (((state_q == FILL) || (state_q == WRITE)) && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            IDLE: begin
                req_d = 1'b0;
                if (start_s) begin
                    addr_d  = i_enet_ddr_dest_addr & 32'hFFFF_FFE0;
                    size_d  = i_enet_rcv_data_size;
                    count_d = 32'd0;
                    lane_d  = {LW{1'b0}};
                    be_d    = {LANES{1'b0}};
                    data_d  = {DDR_DW{1'b0}};
                    cnt_d   = 32'd0;
                    if (i_enet_rcv_data_size == 32'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                if (!i_enet_enable) begin
                    state_d = IDLE;
                end else if (i_rx_valid) begin
                    data_d[{lane_q, 3'b000} +: 8] = i_rx_data;
                    be_d[lane_q] = 1'b1;
                    lane_d  = lane_q + LANE_ONE;
                    count_d = count_inc_s;
                    if (word_end_s) begin
                        state_d = WRITE;
                        req_d   = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            WRITE: begin
                if (i_ddr_wr_ack) begin
                    addr_d = addr_q + STEP;
                    lane_d = {LW{1'b0}};
                    be_d   = {LANES{1'b0}};
                    data_d = {DDR_DW{1'b0}};
                    req_d  = 1'b0;
                    if (!i_enet_enable) begin
                        state_d = IDLE;
                    end else if (count_q == size_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    state_d = WRITE;
                end
            end
            DONE: begin
                if (!i_enet_enable) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            en_prev_q <= 1'b0;
            addr_q    <= 32'd0;
            size_q    <= 32'd0;
            count_q   <= 32'd0;
            cnt_q     <= 32'd0;
            lane_q    <= {LW{1'b0}};
            data_q    <= {DDR_DW{1'b0}};
            be_q      <= {LANES{1'b0}};
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_prev_q <= en_prev_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            count_q   <= count_d;
            cnt_q     <= cnt_d;
            lane_q    <= lane_d;
            data_q    <= data_d;
            be_q      <= be_d;
            req_q     <= req_d;
        end
    end

    assign o_rx_ready     = (state_q == FILL);
    assign o_enet_rx_done = (state_q == DONE);
    assign o_ddr_wr_req   = req_q;
    assign o_ddr_wr_addr  = addr_q;
    assign o_ddr_wr_data  = data_q;
    assign o_ddr_wr_be    = be_q;
    assign o_enet_rx_cnt  = cnt_q;

endmodule
